// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed hex display scanner with anti-ghost gaps and frame-synchronous value update.
// Latency: outputs registered; a loaded value appears at the next digit-0 SHOW entry (frame boundary).
// No backpressure: load is a strobe, last load wins; optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_ctrl #(
  parameter int DIV = 50000,
  parameter int GAP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  blank,
  output logic [3:0]  nibble,
  output logic [3:0]  dig_n,
  output logic        upd_ack,
  output logic        frame
);

  localparam int MAXC = (DIV > GAP) ? DIV : GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic {ST_GAP, ST_SHOW} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pend_valid;

  logic          gap_done;
  logic          show_done;
  logic          xfer;
  logic [15:0]   act_next;
  logic [3:0]    nib_next;
  logic [3:0]    lz_blank;
  logic [3:0]    en_mask;

  // Next-cycle digit content: the transferred value is used on the very edge it becomes active,
  // so the first digit-0 slot of a new frame never shows the previous value.
  always_comb begin
    gap_done  = (state == ST_GAP)  && (cnt == GAP_LAST);
    show_done = (state == ST_SHOW) && (cnt == DIV_LAST);
    xfer      = gap_done && (idx == 2'd0) && pend_valid;
    act_next  = xfer ? pending : active;
    nib_next  = act_next[{idx, 2'b00} +: 4];
    lz_blank  = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank[1] = (act_next[15:4]  == 12'h000);
    lz_blank[2] = (act_next[15:8]  == 8'h00);
    lz_blank[3] = (act_next[15:12] == 4'h0);
`endif
    en_mask   = (4'b0001 << idx) & ~blank & ~lz_blank;
  end

  // Scan FSM with registered digit outputs and the pending/active double buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_GAP;
      idx        <= 2'd0;
      cnt        <= '0;
      active     <= 16'h0000;
      pending    <= 16'h0000;
      pend_valid <= 1'b0;
      nibble     <= 4'h0;
      dig_n      <= 4'b1111;
      upd_ack    <= 1'b0;
      frame      <= 1'b0;
    end else begin
      upd_ack <= 1'b0;
      frame   <= 1'b0;

      // A load on the transfer edge lands here after the old pending was consumed below.
      if (load) begin
        pending    <= value;
        pend_valid <= 1'b1;
      end

      case (state)
        ST_GAP: begin
          dig_n <= 4'b1111;
          if (gap_done) begin
            state  <= ST_SHOW;
            cnt    <= '0;
            nibble <= nib_next;
            dig_n  <= ~en_mask;
            if (idx == 2'd0) begin
              frame <= 1'b1;
            end
            if (xfer) begin
              active  <= pending;
              upd_ack <= 1'b1;
              if (!load) begin
                pend_valid <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (show_done) begin
            state <= ST_GAP;
            cnt   <= '0;
            idx   <= idx + 2'd1;
            dig_n <= 4'b1111;
          end else begin
            cnt    <= cnt + 1'b1;
            nibble <= nib_next;
            dig_n  <= ~en_mask;
          end
        end
        default: begin
          state <= ST_GAP;
          cnt   <= '0;
          dig_n <= 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000, clocks each digit is driven (SHOW length); legal range DIV >= 1.
REQ-002 SHALL have parameter GAP, default 16, all-digits-off clocks between digits (anti-ghosting); legal range GAP >= 1.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port value  input  16  four hex digits; [3:0] is digit 0 (rightmost).
REQ-006 SHALL have port load  input  1  single-cycle strobe capturing value into the pending buffer.
REQ-007 SHALL have port blank  input  4  per-digit force-off mask, sampled live; bit i blanks digit i.
REQ-008 SHALL have port nibble  output  4  hex code for the shared external 4-to-7 decoder.
REQ-009 SHALL have port dig_n  output  4  active-low one-hot digit enable.
REQ-010 SHALL have port upd_ack  output  1  one-cycle pulse when pending moves to active.
REQ-011 SHALL have port frame  output  1  one-cycle pulse at start of each digit-0 SHOW.

Function
REQ-012 SHALL implement a two-state FSM, GAP and SHOW, with digit index idx (0..3) and a down/up counter wide enough for max(DIV,GAP).
REQ-013 GAP SHALL last exactly GAP cycles with dig_n = 4'b1111, then enter SHOW for the current idx.
REQ-014 SHOW SHALL last exactly DIV cycles; on exit idx SHALL advance 0->1->2->3->0 (wrap) and FSM SHALL enter GAP.
REQ-015 A full frame SHALL be exactly 4*(DIV+GAP) cycles.
REQ-016 In SHOW, dig_n SHALL be ~(4'b0001 << idx), or 4'b1111 if blank[idx]=1; nibble SHALL be active[4*idx+3:4*idx].
REQ-017 nibble and dig_n SHALL be registered and change in the same cycle as the state change (no cycle where a new digit is enabled with the old nibble).
REQ-018 In GAP, nibble SHALL hold its last value.
REQ-019 load=1 SHALL write value into pending and set pend_valid; a later load before transfer SHALL overwrite pending (last wins).
REQ-020 On the GAP->SHOW transition with idx=0: if pend_valid, active SHALL take pending, pend_valid SHALL clear, and upd_ack SHALL pulse that cycle; frame SHALL pulse that cycle regardless.
REQ-021 The displayed value SHALL never change mid-frame.
REQ-022 load coincident with a transfer: the old pending SHALL be transferred; the new value SHALL land in pending with pend_valid left set.
REQ-023 blank changes SHALL take effect on the next registered update of dig_n (next SHOW entry or next cycle within SHOW).

Reset
REQ-024 rst=1 SHALL force state=GAP, idx=0, counter=0, active=16'h0000, pending=16'h0000, pend_valid=0, nibble=4'h0, dig_n=4'b1111, upd_ack=0, frame=0.
REQ-025 rst asserted mid-SHOW SHALL turn all digits off the next edge and discard any pending load; load during rst SHALL be ignored.
REQ-026 After rst release, the first digit-0 SHOW SHALL begin exactly GAP cycles later.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN defined: digit i (i = 3,2,1) SHALL also be blanked when active nibbles i..3 are all zero; digit 0 SHALL never be suppressed.
REQ-028 Macro LEADING_ZERO_BLANK_EN undefined: only blank[] SHALL blank digits; all FSM timing is identical in both builds.

Verification (DIV=4, GAP=2 unless stated)
REQ-029 Reset release, no load -> dig_n=1111 for 2 cycles, then 1110 for 4 cycles with nibble=0; frame pulses once; frame period 24 cycles.
REQ-030 load value=16'h1234 mid-digit-2 SHOW -> digits keep old value until next digit-0 entry; then upd_ack=1 for 1 cycle, nibbles 4,3,2,1 on dig_n 1110,1101,1011,0111.
REQ-031 load 16'hAAAA then 16'h5555 within same frame, second coincident with transfer edge -> AAAA displayed, 5555 displayed one frame later with a second upd_ack.
REQ-032 blank=4'b0100, value 16'hFFFF -> digit-2 SHOW slot shows dig_n=1111; other digits show F.
REQ-033 LEADING_ZERO_BLANK_EN defined, value 16'h0007 -> only digit 0 lit (nibble 7); value 16'h0000 -> digit 0 lit with nibble 0.
REQ-034 rst pulsed during digit-1 SHOW after a pending load -> dig_n=1111 next edge, active=0000, no upd_ack at next frame.
